// File: rtl/sdhost_dma_pkg.sv
// Shared SD host DMA encodings: decoded transfer types and block sequencer FSM states.
// Build option AUTO_CMD12_EN adds the CMD12 state and makes it the end state of multiple transfers.
package sdhost_dma_pkg;

    typedef enum logic [1:0] {
        SINGLE        = 2'b00,
        INFINITE      = 2'b01,
        MULTIPLE      = 2'b10,
        STOP_MULTIPLE = 2'b11
    } xfer_type_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_FINISH    = 3'd4,
        ST_ERROR     = 3'd5
`ifdef AUTO_CMD12_EN
        ,
        ST_CMD12     = 3'd6
`endif
    } seq_state_e;

`ifdef AUTO_CMD12_EN
    localparam seq_state_e ST_MULTI_END = ST_CMD12;
`else
    localparam seq_state_e ST_MULTI_END = ST_FINISH;
`endif

    // Transfers that complete without moving any block on the data lines.
    function automatic logic skips_blocks(input xfer_type_e t, input logic cnt_zero);
        return (t == STOP_MULTIPLE) || ((t == MULTIPLE) && cnt_zero);
    endfunction

endpackage

// File: rtl/block_counter.sv
// Loadable down-counter holding the remaining block count; never wraps below zero.
module block_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/block_transfer_sequencer.sv
// SD host DMA block sequencer: issues one Block_Start per block and tracks completion.
// Build option AUTO_CMD12_EN adds the Auto_Cmd12_Req/Ack handshake after multiple transfers.
//
//   state     | meaning
//   IDLE      | waiting for Start
//   ISSUE     | Block_Start pulse (suppressed for zero-block transfers)
//   WAIT_DONE | waiting for Block_Done / Block_Error
//   GAP       | paused at block boundary until Continue_Request
//   FINISH    | Transfer_Complete pulse
//   ERROR     | one cycle after a block error, Error_Status set
//   CMD12     | Auto_Cmd12_Req held until Ack (AUTO_CMD12_EN only)
module block_transfer_sequencer
    import sdhost_dma_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             Start,
    input  logic [1:0]       Transfer_Type,
    input  logic [CNT_W-1:0] Block_Count,
    input  logic             Stop_At_Block_Gap,
    input  logic             Continue_Request,
    input  logic             Abort,
    input  logic             Block_Done,
    input  logic             Block_Error,
`ifdef AUTO_CMD12_EN
    input  logic             Auto_Cmd12_Ack,
    output logic             Auto_Cmd12_Req,
`endif
    output logic             Block_Start,
    output logic             Busy,
    output logic [CNT_W-1:0] Blocks_Remaining,
    output logic             Block_Gap_Event,
    output logic             Transfer_Complete,
    output logic             Error_Status
);

    seq_state_e       state_q, state_d;
    xfer_type_e       type_q, type_d;
    logic             err_q, err_d;
    logic             gap_evt_q, gap_evt_d;

    logic             accept;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             last_blk;
    logic             skip;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load_val;

    assign accept       = (state_q == ST_IDLE) && Start;
    assign cnt_load_val = (Transfer_Type == MULTIPLE) ? Block_Count : '0;
    assign cnt_dec      = (state_q == ST_WAIT_DONE) && Block_Done && !Block_Error && !Abort
                          && (type_q == MULTIPLE);
    assign last_blk     = (cnt == CNT_W'(1)) || cnt_zero;
    assign skip         = skips_blocks(type_q, cnt_zero);

    block_counter #(
        .CNT_W (CNT_W)
    ) u_block_counter (
        .CLK        (CLK),
        .RST_L      (RST_L),
        .load_i     (accept),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q   <= ST_IDLE;
            type_q    <= SINGLE;
            err_q     <= 1'b0;
            gap_evt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            err_q     <= err_d;
            gap_evt_q <= gap_evt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = skip ? ST_FINISH : ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (Block_Error) begin
                    state_d = ST_ERROR;
                end else if (Block_Done) begin
                    if (type_q == SINGLE) begin
                        state_d = ST_FINISH;
                    end else if ((type_q == MULTIPLE) && last_blk) begin
                        state_d = ST_MULTI_END;
                    end else if (Stop_At_Block_Gap) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_GAP: begin
                if (Continue_Request) state_d = ST_ISSUE;
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_IDLE;
`ifdef AUTO_CMD12_EN
            ST_CMD12: begin
                if (Auto_Cmd12_Ack) state_d = ST_FINISH;
            end
`endif
            default:   state_d = ST_IDLE;
        endcase
        // Abort overrides every other transition, including error and completion.
        if (Abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_comb begin
        type_d    = accept ? xfer_type_e'(Transfer_Type) : type_q;
        err_d     = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if ((state_q == ST_WAIT_DONE) && (state_d == ST_ERROR)) begin
            err_d = 1'b1;
        end
        gap_evt_d = (state_q == ST_WAIT_DONE) && (state_d == ST_GAP);
    end

    always_comb begin
        Block_Start       = (state_q == ST_ISSUE) && !skip;
        Busy              = (state_q != ST_IDLE);
        Transfer_Complete = (state_q == ST_FINISH);
        Block_Gap_Event   = gap_evt_q;
        Error_Status      = err_q;
        Blocks_Remaining  = cnt;
`ifdef AUTO_CMD12_EN
        Auto_Cmd12_Req    = (state_q == ST_CMD12);
`endif
    end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed + randomized bench for block_transfer_sequencer; expectations come from transfer arithmetic.
module tb_block_transfer_sequencer;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST_L = 1'b0;
    logic             Start = 1'b0;
    logic [1:0]       Transfer_Type = 2'b00;
    logic [CNT_W-1:0] Block_Count = '0;
    logic             Stop_At_Block_Gap = 1'b0;
    logic             Continue_Request = 1'b0;
    logic             Abort = 1'b0;
    logic             Block_Done = 1'b0;
    logic             Block_Error = 1'b0;
    logic             Block_Start;
    logic             Busy;
    logic [CNT_W-1:0] Blocks_Remaining;
    logic             Block_Gap_Event;
    logic             Transfer_Complete;
    logic             Error_Status;
`ifdef AUTO_CMD12_EN
    logic             Auto_Cmd12_Ack = 1'b0;
    logic             Auto_Cmd12_Req;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int bs_seen  = 0;
    int tc_seen  = 0;
    int gap_seen = 0;

    block_transfer_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK               (CLK),
        .RST_L             (RST_L),
        .Start             (Start),
        .Transfer_Type     (Transfer_Type),
        .Block_Count       (Block_Count),
        .Stop_At_Block_Gap (Stop_At_Block_Gap),
        .Continue_Request  (Continue_Request),
        .Abort             (Abort),
        .Block_Done        (Block_Done),
        .Block_Error       (Block_Error),
`ifdef AUTO_CMD12_EN
        .Auto_Cmd12_Ack    (Auto_Cmd12_Ack),
        .Auto_Cmd12_Req    (Auto_Cmd12_Req),
`endif
        .Block_Start       (Block_Start),
        .Busy              (Busy),
        .Blocks_Remaining  (Blocks_Remaining),
        .Block_Gap_Event   (Block_Gap_Event),
        .Transfer_Complete (Transfer_Complete),
        .Error_Status      (Error_Status)
    );

    always #5 CLK = ~CLK;

    // Pulse counters sampled mid-cycle, one count per high cycle.
    always @(negedge CLK) begin
        if (Block_Start)       bs_seen++;
        if (Transfer_Complete) tc_seen++;
        if (Block_Gap_Event)   gap_seen++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no end of run, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_xfer(input logic [1:0] t, input logic [CNT_W-1:0] cnt);
        Transfer_Type = t;
        Block_Count   = cnt;
        Start         = 1'b1;
        step();
        Start         = 1'b0;
        Transfer_Type = 2'($urandom);
        Block_Count   = CNT_W'($urandom);
    endtask

    task automatic run_single();
        int bs0, tc0;
        bs0 = bs_seen;
        tc0 = tc_seen;
        start_xfer(2'b00, CNT_W'($urandom));
        check("single_busy", 32'(Busy), 1);
        check("single_bs_n1", 32'(Block_Start), 1);
        check("single_err_clr", 32'(Error_Status), 0);
        check("single_rem", 32'(Blocks_Remaining), 0);
        step();
        check("single_bs_one_cycle", 32'(Block_Start), 0);
        Transfer_Type = 2'b10;
        Block_Count   = CNT_W'(9);
        Start         = 1'b1;
        step();
        Start         = 1'b0;
        check("busy_start_rem", 32'(Blocks_Remaining), 0);
        check("busy_start_bs", 32'(Block_Start), 0);
        repeat ($urandom_range(0, 3)) step();
        Block_Done = 1'b1;
        step();
        Block_Done = 1'b0;
        check("single_complete", 32'(Transfer_Complete), 1);
        step();
        check("single_complete_pulse", 32'(Transfer_Complete), 0);
        check("single_idle", 32'(Busy), 0);
        check("single_starts", 32'(bs_seen - bs0), 1);
        check("single_completes", 32'(tc_seen - tc0), 1);
    endtask

    task automatic run_multiple(input int n, input int gap_blk);
        int bs0, tc0, gp0, bs_gap;
        bs0 = bs_seen;
        tc0 = tc_seen;
        gp0 = gap_seen;
        start_xfer(2'b10, CNT_W'(n));
        check("mul_rem_load", 32'(Blocks_Remaining), n);
        for (int blk = 1; blk <= n; blk++) begin
            check("mul_block_start", 32'(Block_Start), 1);
            step();
            repeat ($urandom_range(0, 3)) step();
            check("mul_rem_wait", 32'(Blocks_Remaining), n - blk + 1);
            Stop_At_Block_Gap = (blk == gap_blk);
            Block_Done = 1'b1;
            step();
            Block_Done = 1'b0;
            check("mul_rem_done", 32'(Blocks_Remaining), n - blk);
            if (blk == n) begin
`ifdef AUTO_CMD12_EN
                check("cmd12_req", 32'(Auto_Cmd12_Req), 1);
                check("cmd12_no_complete", 32'(Transfer_Complete), 0);
                repeat (2) step();
                check("cmd12_req_held", 32'(Auto_Cmd12_Req), 1);
                Auto_Cmd12_Ack = 1'b1;
                step();
                Auto_Cmd12_Ack = 1'b0;
                check("cmd12_req_drop", 32'(Auto_Cmd12_Req), 0);
`endif
                check("mul_complete", 32'(Transfer_Complete), 1);
            end else if (blk == gap_blk) begin
                bs_gap = bs_seen;
                check("gap_event", 32'(Block_Gap_Event), 1);
                step();
                check("gap_event_pulse", 32'(Block_Gap_Event), 0);
                repeat (3) step();
                check("gap_no_start", 32'(bs_seen - bs_gap), 0);
                check("gap_busy", 32'(Busy), 1);
                check("gap_rem", 32'(Blocks_Remaining), n - blk);
                Stop_At_Block_Gap = 1'b0;
                Continue_Request  = 1'b1;
                step();
                Continue_Request  = 1'b0;
            end
        end
        Stop_At_Block_Gap = 1'b0;
        step();
        check("mul_idle", 32'(Busy), 0);
        check("mul_starts", 32'(bs_seen - bs0), n);
        check("mul_completes", 32'(tc_seen - tc0), 1);
        check("mul_gap_events", 32'(gap_seen - gp0), (gap_blk > 0) ? 1 : 0);
    endtask

    task automatic run_zero_block(input logic [1:0] t, input logic [CNT_W-1:0] cnt);
        int bs0, tc0;
        bs0 = bs_seen;
        tc0 = tc_seen;
        start_xfer(t, cnt);
        check("zero_busy_n1", 32'(Busy), 1);
        check("zero_no_bs_n1", 32'(Block_Start), 0);
        check("zero_no_complete_n1", 32'(Transfer_Complete), 0);
        step();
        check("zero_complete_n2", 32'(Transfer_Complete), 1);
        step();
        check("zero_idle", 32'(Busy), 0);
        check("zero_starts", 32'(bs_seen - bs0), 0);
        check("zero_completes", 32'(tc_seen - tc0), 1);
    endtask

    initial begin
        int bs0, tc0, k, n, g;

        repeat (3) step();
        check("rst_busy", 32'(Busy), 0);
        check("rst_bs", 32'(Block_Start), 0);
        check("rst_rem", 32'(Blocks_Remaining), 0);
        check("rst_gap", 32'(Block_Gap_Event), 0);
        check("rst_complete", 32'(Transfer_Complete), 0);
        check("rst_err", 32'(Error_Status), 0);
        RST_L = 1'b1;
        step();

        run_single();
        run_multiple(3, 0);
        run_multiple(4, 2);

        // Error and Done together on block 1 of 5: error wins, no decrement, no completion.
        bs0 = bs_seen;
        tc0 = tc_seen;
        start_xfer(2'b10, CNT_W'(5));
        check("err_bs", 32'(Block_Start), 1);
        step();
        Block_Error = 1'b1;
        Block_Done  = 1'b1;
        step();
        Block_Error = 1'b0;
        Block_Done  = 1'b0;
        check("err_status", 32'(Error_Status), 1);
        check("err_busy", 32'(Busy), 1);
        check("err_rem", 32'(Blocks_Remaining), 5);
        step();
        check("err_idle", 32'(Busy), 0);
        check("err_sticky", 32'(Error_Status), 1);
        step();
        check("err_no_complete", 32'(tc_seen - tc0), 0);
        check("err_starts", 32'(bs_seen - bs0), 1);
        run_single();

        // Infinite transfer ended by Abort, with a same-cycle Block_Done that must lose.
        bs0 = bs_seen;
        tc0 = tc_seen;
        start_xfer(2'b01, CNT_W'($urandom));
        k = $urandom_range(1, 4);
        for (int b = 0; b < k; b++) begin
            check("inf_bs", 32'(Block_Start), 1);
            step();
            repeat ($urandom_range(0, 3)) step();
            Block_Done = 1'b1;
            step();
            Block_Done = 1'b0;
            check("inf_rem", 32'(Blocks_Remaining), 0);
        end
        check("inf_bs_last", 32'(Block_Start), 1);
        step();
        Abort      = 1'b1;
        Block_Done = 1'b1;
        step();
        Abort      = 1'b0;
        Block_Done = 1'b0;
        check("abort_idle", 32'(Busy), 0);
        check("abort_no_bs", 32'(Block_Start), 0);
        step();
        check("abort_no_complete", 32'(tc_seen - tc0), 0);
        check("inf_starts", 32'(bs_seen - bs0), k + 1);

        run_zero_block(2'b10, '0);
        run_zero_block(2'b11, CNT_W'($urandom_range(1, 100)));

        // Asynchronous reset while in the error cycle of a multiple transfer.
        start_xfer(2'b10, CNT_W'(4));
        step();
        Block_Error = 1'b1;
        step();
        Block_Error = 1'b0;
        check("pre_rst_busy", 32'(Busy), 1);
        check("pre_rst_err", 32'(Error_Status), 1);
        #2;
        RST_L = 1'b0;
        #1;
        check("mid_rst_busy", 32'(Busy), 0);
        check("mid_rst_err", 32'(Error_Status), 0);
        check("mid_rst_rem", 32'(Blocks_Remaining), 0);
        check("mid_rst_bs", 32'(Block_Start), 0);
        check("mid_rst_complete", 32'(Transfer_Complete), 0);
        step();
        RST_L = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(1, 8);
            g = 0;
            if ((n > 1) && ($urandom_range(0, 1) == 1)) g = $urandom_range(1, n - 1);
            run_multiple(n, g);
        end
        run_single();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
